// File: rtl/pwm_capture.sv
// PWM capture: recovers duty (high steps) and period (rise-to-rise steps) from a PWM line.
// Optional duty averaging of consecutive measurements is enabled by defining PWM_CAPTURE_AVG_EN.
module pwm_capture #(
  parameter int unsigned N             = 4,
  parameter int unsigned PERIOD_W      = 6,
  parameter int unsigned TIMEOUT_STEPS = 32,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                pwm_in,
  output logic [N-1:0]        duty,
  output logic [PERIOD_W-1:0] period,
  output logic                valid,
  output logic                stuck
);

  localparam int unsigned DutyMax = (1 << N) - 1;
  localparam logic [PERIOD_W-1:0] CntMax     = '1;
  localparam logic [PERIOD_W-1:0] TimeoutCnt = PERIOD_W'(TIMEOUT_STEPS - 1);

  typedef enum logic {StSeek, StMeasure} state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                s, prev_q, prev_d, rise, timeout;
  logic [PERIOD_W-1:0] high_q, high_d, per_q, per_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [N-1:0]        duty_q, duty_d, meas, pub;
  logic                valid_q, valid_d, stuck_q, stuck_d;

`ifdef PWM_CAPTURE_AVG_EN
  logic [N-1:0] hist_q, hist_d;
  logic         hist_vld_q, hist_vld_d;
  logic [N:0]   sum;
`endif

  assign s    = sync_q[SYNC_STAGES-1];
  assign meas = (high_q > PERIOD_W'(DutyMax)) ? '1 : high_q[N-1:0];

`ifdef PWM_CAPTURE_AVG_EN
  assign sum = {1'b0, hist_q} + {1'b0, meas};
  assign pub = hist_vld_q ? N'(sum >> 1) : meas;
`else
  assign pub = meas;
`endif

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    high_d   = high_q;
    per_d    = per_q;
    duty_d   = duty_q;
    period_d = period_q;
    stuck_d  = stuck_q;
    valid_d  = 1'b0;
`ifdef PWM_CAPTURE_AVG_EN
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
`endif
    rise    = s & ~prev_q;
    timeout = ~rise & (per_q == TimeoutCnt);
    if (ena) begin
      prev_d = s;
      if (rise) begin
        // The rising step itself is the first high step of the new period.
        high_d  = PERIOD_W'(1);
        per_d   = PERIOD_W'(1);
        state_d = StMeasure;
        if (state_q == StMeasure) begin
          duty_d   = pub;
          period_d = per_q;
          valid_d  = 1'b1;
          stuck_d  = 1'b0;
`ifdef PWM_CAPTURE_AVG_EN
          hist_d     = meas;
          hist_vld_d = 1'b1;
`endif
        end
      end else if (timeout) begin
        duty_d   = {N{s}};
        period_d = '0;
        stuck_d  = 1'b1;
        valid_d  = 1'b1;
        high_d   = '0;
        per_d    = '0;
        state_d  = StSeek;
`ifdef PWM_CAPTURE_AVG_EN
        hist_vld_d = 1'b0;
`endif
      end else begin
        per_d = (per_q == CntMax) ? per_q : per_q + PERIOD_W'(1);
        if (state_q == StMeasure && s && high_q != CntMax) begin
          high_d = high_q + PERIOD_W'(1);
        end
      end
    end
  end

  // The synchronizer runs every clock, independent of ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StSeek;
      prev_q   <= 1'b1;
      high_q   <= '0;
      per_q    <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
`ifdef PWM_CAPTURE_AVG_EN
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      high_q   <= high_d;
      per_q    <= per_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
`ifdef PWM_CAPTURE_AVG_EN
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
`endif
    end
  end

  assign duty   = duty_q;
  assign period = period_q;
  assign valid  = valid_q;
  assign stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: randomized PWM stimulus against a window-based reference
// model (high steps / total steps since the last rise), plus directed checks of key values.
module tb_pwm_capture;

  localparam int Nw      = 4;
  localparam int Pw      = 6;
  localparam int Timeout = 32;
  localparam int Sync    = 2;

  logic          clk = 1'b0;
  logic          rst, ena, pwm_in;
  logic [Nw-1:0] duty;
  logic [Pw-1:0] period;
  logic          valid, stuck;

  pwm_capture #(
    .N(Nw), .PERIOD_W(Pw), .TIMEOUT_STEPS(Timeout), .SYNC_STAGES(Sync)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .pwm_in(pwm_in),
    .duty(duty), .period(period), .valid(valid), .stuck(stuck)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  bit            m_dly[Sync];
  bit            m_prev, m_seek, m_hist_ok;
  int            m_hist;
  bit            win[$];
  logic [Nw-1:0] e_duty;
  logic [Pw-1:0] e_period;
  logic          e_valid, e_stuck;

  // Bench PWM source: out = count < duty, count advances on ena steps
  int pg_cnt = 0;
  int pg_duty = 0;

  task automatic model_step();
    bit s, rise;
    int sum, meas;
    if (rst) begin
      foreach (m_dly[i]) m_dly[i] = 1'b0;
      m_prev = 1'b1; m_seek = 1'b1; m_hist_ok = 1'b0; m_hist = 0;
      win.delete();
      e_duty = '0; e_period = '0; e_valid = 1'b0; e_stuck = 1'b0;
    end else begin
      s = m_dly[Sync-1];
      for (int i = Sync - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
      m_dly[0] = pwm_in;
      e_valid = 1'b0;
      if (ena) begin
        rise = s && !m_prev;
        m_prev = s;
        if (rise) begin
          if (!m_seek) begin
            sum = 0;
            foreach (win[i]) sum += int'(win[i]);
            meas = (sum > 15) ? 15 : sum;
`ifdef PWM_CAPTURE_AVG_EN
            e_duty = m_hist_ok ? Nw'((m_hist + meas) / 2) : Nw'(meas);
            m_hist = meas;
            m_hist_ok = 1'b1;
`else
            e_duty = Nw'(meas);
`endif
            e_period = Pw'((win.size() > 63) ? 63 : win.size());
            e_valid = 1'b1;
            e_stuck = 1'b0;
          end
          m_seek = 1'b0;
          win.delete();
          win.push_back(1'b1);
        end else if (win.size() == Timeout - 1) begin
          e_duty = s ? 4'hF : 4'h0;
          e_period = '0;
          e_stuck = 1'b1;
          e_valid = 1'b1;
          m_seek = 1'b1;
          m_hist_ok = 1'b0;
          win.delete();
        end else begin
          win.push_back(s);
        end
      end
    end
  endtask

  task automatic tick(input bit r, input bit e, input bit p);
    @(negedge clk);
    rst = r; ena = e; pwm_in = p;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pwm_tick(input bit e);
    tick(1'b0, e, pg_cnt < pg_duty);
    if (e) pg_cnt = (pg_cnt + 1) % 16;
  endtask

  task automatic do_reset();
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    pg_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (duty !== 4'h0) $display("FAIL reset_duty: got %0d want 0", duty); else n_pass++;
    n_chk++;
    if (period !== 6'd0) $display("FAIL reset_period: got %0d want 0", period); else n_pass++;
    n_chk++;
    if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
    n_chk++;
    if (stuck !== 1'b0) $display("FAIL reset_stuck: got %b want 0", stuck); else n_pass++;
  endtask

  task automatic test_pwm_loop();
    int duties[4];
    duties[0] = 5;
    for (int k = 1; k < 4; k++) duties[k] = $urandom_range(1, 15);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pg_duty = duties[k];
      for (int c = 0; c < 80; c++) begin
        pwm_tick(1'b1);
        n_chk++;
        if ({valid, stuck, duty, period} !== {e_valid, e_stuck, e_duty, e_period})
          $display("FAIL pwm_loop t=%0t: got v=%b s=%b d=%0d p=%0d want v=%b s=%b d=%0d p=%0d",
                   $time, valid, stuck, duty, period, e_valid, e_stuck, e_duty, e_period);
        else n_pass++;
      end
      n_chk++;
      if (duty !== 4'(duties[k]) || period !== 6'd16 || stuck !== 1'b0)
        $display("FAIL pwm_loop_final: got d=%0d p=%0d s=%b want d=%0d p=16 s=0",
                 duty, period, stuck, duties[k]);
      else n_pass++;
    end
  endtask

  task automatic test_stuck_low();
    int nv = 0;
    do_reset();
    for (int c = 0; c < 70; c++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (valid) nv++;
      n_chk++;
      if ({valid, stuck, duty, period} !== {e_valid, e_stuck, e_duty, e_period})
        $display("FAIL stuck_low t=%0t: got v=%b s=%b d=%0d p=%0d want v=%b s=%b d=%0d p=%0d",
                 $time, valid, stuck, duty, period, e_valid, e_stuck, e_duty, e_period);
      else n_pass++;
    end
    n_chk++;
    if (nv !== 2 || stuck !== 1'b1 || duty !== 4'h0 || period !== 6'd0)
      $display("FAIL stuck_low_final: got nv=%0d s=%b d=%0d p=%0d want nv=2 s=1 d=0 p=0",
               nv, stuck, duty, period);
    else n_pass++;
  endtask

  task automatic test_stuck_high();
    int nv = 0;
    repeat (3) tick(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b1, 1'b1);
      if (valid) nv++;
      n_chk++;
      if ({valid, stuck, duty, period} !== {e_valid, e_stuck, e_duty, e_period})
        $display("FAIL stuck_high t=%0t: got v=%b s=%b d=%0d p=%0d want v=%b s=%b d=%0d p=%0d",
                 $time, valid, stuck, duty, period, e_valid, e_stuck, e_duty, e_period);
      else n_pass++;
    end
    n_chk++;
    if (nv !== 1 || stuck !== 1'b1 || duty !== 4'hF)
      $display("FAIL stuck_high_final: got nv=%0d s=%b d=%0d want nv=1 s=1 d=15", nv, stuck, duty);
    else n_pass++;
    pg_cnt = 0;
    pg_duty = 9;
    for (int c = 0; c < 50; c++) begin
      pwm_tick(1'b1);
      n_chk++;
      if ({valid, stuck, duty, period} !== {e_valid, e_stuck, e_duty, e_period})
        $display("FAIL stuck_recover t=%0t: got v=%b s=%b d=%0d p=%0d want v=%b s=%b d=%0d p=%0d",
                 $time, valid, stuck, duty, period, e_valid, e_stuck, e_duty, e_period);
      else n_pass++;
    end
    n_chk++;
    if (stuck !== 1'b0 || duty !== 4'd9)
      $display("FAIL stuck_recover_final: got s=%b d=%0d want s=0 d=9", stuck, duty);
    else n_pass++;
  endtask

  task automatic test_ena_gated();
    do_reset();
    pg_duty = 12;
    for (int c = 0; c < 260; c++) begin
      pwm_tick(c % 4 == 0);
      n_chk++;
      if ({valid, stuck, duty, period} !== {e_valid, e_stuck, e_duty, e_period})
        $display("FAIL ena_gated t=%0t: got v=%b s=%b d=%0d p=%0d want v=%b s=%b d=%0d p=%0d",
                 $time, valid, stuck, duty, period, e_valid, e_stuck, e_duty, e_period);
      else n_pass++;
    end
    n_chk++;
    if (duty !== 4'd12 || period !== 6'd16)
      $display("FAIL ena_gated_final: got d=%0d p=%0d want d=12 p=16", duty, period);
    else n_pass++;
  endtask

  task automatic test_long_high();
    do_reset();
    for (int c = 0; c < 110; c++) begin
      tick(1'b0, 1'b1, (c % 24) < 20);
      n_chk++;
      if ({valid, stuck, duty, period} !== {e_valid, e_stuck, e_duty, e_period})
        $display("FAIL long_high t=%0t: got v=%b s=%b d=%0d p=%0d want v=%b s=%b d=%0d p=%0d",
                 $time, valid, stuck, duty, period, e_valid, e_stuck, e_duty, e_period);
      else n_pass++;
    end
    n_chk++;
    if (duty !== 4'hF || period !== 6'd24)
      $display("FAIL long_high_final: got d=%0d p=%0d want d=15 p=24", duty, period);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    do_reset();
    pg_duty = 7;
    repeat (25) pwm_tick(1'b1);
    do_reset();
    pg_duty = 3;
    for (int c = 0; c < 40; c++) begin
      pwm_tick(1'b1);
      n_chk++;
      if ({valid, stuck, duty, period} !== {e_valid, e_stuck, e_duty, e_period})
        $display("FAIL reset_mid t=%0t: got v=%b s=%b d=%0d p=%0d want v=%b s=%b d=%0d p=%0d",
                 $time, valid, stuck, duty, period, e_valid, e_stuck, e_duty, e_period);
      else n_pass++;
      if (valid && !seen) begin
        seen = 1'b1;
        n_chk++;
        if (duty !== 4'd3 || period !== 6'd16)
          $display("FAIL reset_mid_first: got d=%0d p=%0d want d=3 p=16", duty, period);
        else n_pass++;
      end
    end
    n_chk++;
    if (!seen) $display("FAIL reset_mid_seen: got no valid want one"); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      pg_duty = $urandom_range(0, 15);
      for (int c = 0; c < 150; c++) begin
        pwm_tick(1'($urandom_range(0, 1)));
        n_chk++;
        if ({valid, stuck, duty, period} !== {e_valid, e_stuck, e_duty, e_period})
          $display("FAIL random t=%0t: got v=%b s=%b d=%0d p=%0d want v=%b s=%b d=%0d p=%0d",
                   $time, valid, stuck, duty, period, e_valid, e_stuck, e_duty, e_period);
        else n_pass++;
      end
    end
  endtask

`ifdef PWM_CAPTURE_AVG_EN
  task automatic test_avg();
    int got[$];
    do_reset();
    pg_duty = 4;
    repeat (16) pwm_tick(1'b1);
    pg_duty = 8;
    for (int c = 0; c < 56; c++) begin
      pwm_tick(1'b1);
      if (valid) got.push_back(int'(duty));
    end
    n_chk++;
    if (got.size() < 3 || got[0] != 4 || got[1] != 6 || got[2] != 8)
      $display("FAIL avg_seq: got %p want 4 6 8", got);
    else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1; ena = 1'b0; pwm_in = 1'b0;
    test_reset();
    test_pwm_loop();
    test_stuck_low();
    test_stuck_high();
    test_ena_gated();
    test_long_high();
    test_reset_mid();
    test_random();
`ifdef PWM_CAPTURE_AVG_EN
    test_avg();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
